// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Raster timing generator. Produces pixel coordinates, the
//             display-active qualifier, active-low sync pulses and the
//             frame_start / line_end strobes. Every output is registered
//             and describes the same (DrawX, DrawY) in any given cycle.
//  Ports    : vga_clk      in   pixel clock
//             reset        in   asynchronous active-high reset
//             DrawX        out  horizontal position, 0..H_TOTAL-1
//             DrawY        out  vertical position, 0..V_TOTAL-1
//             hs / vs      out  horizontal / vertical sync, active low
//             blank        out  1 = visible pixel
//             frame_start  out  pulse at (0,0)
//             line_end     out  pulse at DrawX = H_TOTAL-1
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       line_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  c_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST     = 10'(V_TOTAL - 1);
    // Region bounds can reach 1024, so they are compared in 11 bits.
    localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Coordinates are 10 bits wide; larger rasters cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic [9:0]  h_q, v_q;
    logic [9:0]  h_d, v_d;
    logic [10:0] hx_d, vy_d;
    logic        hs_d, vs_d, blank_d, fs_d, le_d;

    // Next position. The outputs are computed from the next position so
    // that the registered outputs line up with the registered coordinates.
    always_comb begin
        h_d     = (h_q == c_H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d     = v_q;
        if (h_q == c_H_LAST) begin
            v_d = (v_q == c_V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        hx_d    = {1'b0, h_d};
        vy_d    = {1'b0, v_d};
        hs_d    = !((hx_d >= c_HS_START) && (hx_d < c_HS_END));
        vs_d    = !((vy_d >= c_VS_START) && (vy_d < c_VS_END));
        blank_d = (hx_d < c_H_ACT) && (vy_d < c_V_ACT);
        fs_d    = (h_d == 10'd0) && (v_d == 10'd0);
        le_d    = (h_d == c_H_LAST);
    end

    // Counters park on the last pixel of the frame during reset so that the
    // first edge after release lands exactly on (0,0).
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_q         <= c_H_LAST;
            v_q         <= c_V_LAST;
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            DrawX       <= h_d;
            DrawY       <= v_d;
            hs          <= hs_d;
            vs          <= vs_d;
            blank       <= blank_d;
            frame_start <= fs_d;
            line_end    <= le_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. A small raster instance
//             covers complete frames and wrap corners; a default-size
//             instance covers the standard line timing and reset behaviour.
//             Expected outputs come from a linear pixel-index model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       le;
    } out_t;

    logic clk;
    logic rst;

    // Small raster: 25 x 17 = 425 pixels per frame
    logic [9:0] a_x, a_y;
    logic       a_hs, a_vs, a_blank, a_fs, a_le;
    // Default raster: 800 x 525
    logic [9:0] b_x, b_y;
    logic       b_hs, b_vs, b_blank, b_fs, b_le;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .vga_clk(clk), .reset(rst),
        .DrawX(a_x), .DrawY(a_y), .hs(a_hs), .vs(a_vs), .blank(a_blank),
        .frame_start(a_fs), .line_end(a_le)
    );

    vga_timing_gen u_dflt (
        .vga_clk(clk), .reset(rst),
        .DrawX(b_x), .DrawY(b_y), .hs(b_hs), .vs(b_vs), .blank(b_blank),
        .frame_start(b_fs), .line_end(b_le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t qa[$];
    out_t qb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    bit   running = 1'b0;

    // Reference: idx < 0 means reset asserted, otherwise idx is the linear
    // pixel number within the frame (row-major).
    function automatic out_t model(input int idx,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb);
        out_t o;
        int   ht, x, y;
        ht = ha + hf + hsw + hb;
        if (idx < 0) begin
            o = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, le: 1'b0};
        end else begin
            x       = idx % ht;
            y       = idx / ht;
            o.x     = 10'(x);
            o.y     = 10'(y);
            o.hs    = !(x >= ha + hf && x < ha + hf + hsw);
            o.vs    = !(y >= va + vf && y < va + vf + vsw);
            o.blank = (x < ha) && (y < va);
            o.fs    = (idx == 0);
            o.le    = (x == ht - 1);
        end
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b le=%b, exp x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b le=%b",
                     name, cyc, got.x, got.y, got.hs, got.vs, got.blank, got.fs, got.le,
                     exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.fs, exp.le);
        end
    endtask

    // Stimulus + expectation producer
    initial begin
        int idx_a, idx_b, hold;
        idx_a = -1;
        idx_b = -1;
        hold  = 0;
        rst   = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            cyc = i;
            // Position advances on every edge where reset is low.
            if (!rst) begin
                idx_a = (idx_a + 1) % 425;
                idx_b = (idx_b + 1) % 420000;
            end
            #1;
            // Reset control: 5 cycles at start, a forced mid-line reset on
            // the default raster, and random asynchronous pulses afterwards.
            if (i < 5) begin
                rst = 1'b1;
            end else if (i == 5) begin
                rst = 1'b0;
            end else if (rst) begin
                if (hold > 0) hold--;
                else rst = 1'b0;
            end else if (idx_b == 300 && i < 1000) begin
                rst  = 1'b1;
                hold = 2;
            end else if (i > 2000 && $urandom_range(0, 1499) == 0) begin
                rst  = 1'b1;
                hold = $urandom_range(0, 3);
            end
            if (rst) begin
                idx_a = -1;
                idx_b = -1;
            end
            qa.push_back(model(idx_a, 16, 2, 4, 3, 10, 2, 2, 3));
            qb.push_back(model(idx_b, 640, 16, 96, 48, 480, 10, 2, 33));
            running = 1'b1;
        end
        @(posedge clk);
        running = 1'b0;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Monitor: samples away from the active edge and compares with the
    // oldest pending expectation.
    always @(negedge clk) begin
        if (running) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL scoreboard_empty cyc=%0d qa=%0d qb=%0d required nonzero",
                         cyc, qa.size(), qb.size());
            end else begin
                check("small", '{x: a_x, y: a_y, hs: a_hs, vs: a_vs, blank: a_blank, fs: a_fs, le: a_le},
                      qa.pop_front());
                check("default", '{x: b_x, y: b_y, hs: b_hs, vs: b_vs, blank: b_blank, fs: b_fs, le: b_le},
                      qb.pop_front());
            end
        end
    end

endmodule
`default_nettype wire
